// File: rtl/ps2_device_tx_if.sv
// Byte push handshake into the PS/2 device transmitter.
interface ps2_device_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: byte FIFO feeding an 11-bit frame serialiser
// that generates ps2_clk/ps2_data, with host inhibit abort and retransmit.
module ps2_device_tx #(
    parameter int unsigned HALF_PERIOD = 8,
    parameter int unsigned GAP_CYCLES  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic           clk,
    input  logic           resetn,
    ps2_device_tx_if.slave in_if,
    input  logic           inhibit,
    output logic           ps2_clk,
    output logic           ps2_data,
    output logic           busy
);
    localparam int unsigned CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] HP_LAST    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       bit_idx, bit_idx_next;
    logic [7:0]       tx_byte, tx_byte_next;
    logic             pending, pending_next;
    logic             clk_next, data_next;
    logic             inhibit_q;
    logic             abort;
    logic [10:0]      frame;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_avail;
    logic             push, pop;

    assign in_if.in_ready = (fifo_count != FULL_COUNT);
    assign push  = in_if.in_valid && in_if.in_ready;
    assign busy  = (state != IDLE) || pending;
    assign frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign abort = inhibit_q && ((state == HIGH) || (state == LOW));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_if.in_data;
    end

    // fifo_avail lags the count by one cycle, giving the two-cycle start latency.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_avail <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            fifo_avail <= (fifo_count != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            tx_byte   <= '0;
            pending   <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            inhibit_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            tx_byte   <= tx_byte_next;
            pending   <= pending_next;
            ps2_clk   <= clk_next;
            ps2_data  <= data_next;
            inhibit_q <= inhibit;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        tx_byte_next = tx_byte;
        pending_next = pending;
        clk_next     = ps2_clk;
        data_next    = ps2_data;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (!inhibit_q && (pending || fifo_avail)) begin
                    if (!pending) begin
                        pop          = 1'b1;
                        tx_byte_next = mem[rd_ptr];
                    end
                    bit_idx_next = '0;
                    clk_next     = 1'b1;
                    data_next    = 1'b0;
                    state_next   = HIGH;
                end
            end
            HIGH: begin
                if (cnt == HP_LAST) begin
                    cnt_next   = '0;
                    clk_next   = 1'b0;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (cnt == HP_LAST) begin
                    cnt_next = '0;
                    clk_next = 1'b1;
                    if (bit_idx == 4'd10) begin
                        data_next    = 1'b1;
                        pending_next = 1'b0;
                        state_next   = GAP;
                    end else begin
                        bit_idx_next = bit_idx + 4'd1;
                        data_next    = frame[bit_idx_next];
                        state_next   = HIGH;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides the phase logic; the byte stays in tx_byte for retransmit.
        if (abort) begin
            state_next   = IDLE;
            cnt_next     = '0;
            clk_next     = 1'b1;
            data_next    = 1'b1;
            pending_next = 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// Randomised self-checking bench for ps2_device_tx: a host-side line monitor
// decodes frames and is compared against a byte-level frame model.
module tb_ps2_device_tx;
    localparam int HP    = 4;
    localparam int GAP   = 12;
    localparam int DEPTH = 8;
    localparam int P     = 22 * HP + GAP + 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic inhibit = 1'b0;
    logic ps2_clk, ps2_data, busy;

    ps2_device_tx_if bif ();

    ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_if(bif), .inhibit(inhibit),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Host-side monitor: frame starts when data drops while the clock has been high with data high.
    logic        prev_clk = 1'b1, prev_data = 1'b1;
    logic [10:0] sh;
    int          nbits = 0, start_c = 0, fall0 = 0, n_starts = 0, stab_err = 0;
    logic [10:0] rx_frame [$];
    int          rx_start [$];
    int          rx_fall0 [$];

    always @(negedge clk) begin
        if (ps2_clk === 1'b1 && ps2_data === 1'b0 && prev_clk === 1'b1 && prev_data === 1'b1) begin
            nbits = 0;
            start_c = cyc;
            n_starts++;
        end
        if (ps2_clk === 1'b0 && prev_clk === 1'b1) begin
            if (nbits == 0) fall0 = cyc;
            if (nbits < 11) begin
                sh[nbits] = ps2_data;
                nbits++;
            end
            if (nbits == 11) begin
                rx_frame.push_back(sh);
                rx_start.push_back(start_c);
                rx_fall0.push_back(fall0);
                nbits = 0;
            end
        end
        if (ps2_clk === 1'b0 && ps2_data !== prev_data) stab_err++;
        prev_clk = ps2_clk;
        prev_data = ps2_data;
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            if (b[i]) ones++;
        end
        f[9] = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rx;
        rx_frame.delete();
        rx_start.delete();
        rx_fall0.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, output int t);
        @(negedge clk);
        bif.in_data = b;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        bif.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (rx_frame.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_total++;
        if (rx_frame.size() < n) $display("FAIL %s: frames got %0d expected %0d", name, rx_frame.size(), n);
        else n_pass++;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s: busy got %b expected 0", name, busy);
        else n_pass++;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        n_total++; if (ps2_clk !== 1'b1) $display("FAIL reset_clk: got %b expected 1", ps2_clk); else n_pass++;
        n_total++; if (ps2_data !== 1'b1) $display("FAIL reset_data: got %b expected 1", ps2_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bif.in_ready); else n_pass++;
    endtask

    task automatic test_single;
        int t;
        clear_rx();
        push_byte(8'h1C, t);
        wait_frames(1, P + 20, "single_frames");
        n_total++; if (rx_start[0] !== t + 2) $display("FAIL single_latency: got %0d expected %0d", rx_start[0], t + 2); else n_pass++;
        n_total++; if (rx_fall0[0] !== rx_start[0] + HP) $display("FAIL single_first_fall: got %0d expected %0d", rx_fall0[0], rx_start[0] + HP); else n_pass++;
        n_total++; if (rx_frame[0] !== 11'b10000111000) $display("FAIL single_bits: got %b expected %b", rx_frame[0], 11'b10000111000); else n_pass++;
        n_total++; if (rx_frame[0][8:1] !== 8'h1C) $display("FAIL single_byte: got %h expected 1c", rx_frame[0][8:1]); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy_gap: got %b expected 1", busy); else n_pass++;
        wait_idle(P, "single_idle");
        n_total++; if ({ps2_clk, ps2_data} !== 2'b11) $display("FAIL single_lines_idle: got %b expected 11", {ps2_clk, ps2_data}); else n_pass++;
    endtask

    task automatic test_parity;
        logic [7:0] bytes [3];
        logic       par [3];
        int         t;
        bytes = '{8'h00, 8'hFF, 8'h01};
        par = '{1'b1, 1'b1, 1'b0};
        clear_rx();
        for (int i = 0; i < 3; i++) push_byte(bytes[i], t);
        wait_frames(3, 3 * P + 20, "parity_frames");
        for (int i = 0; i < 3; i++) begin
            n_total++; if (rx_frame[i] !== model_frame(bytes[i])) $display("FAIL parity_frame%0d: got %b expected %b", i, rx_frame[i], model_frame(bytes[i])); else n_pass++;
            n_total++; if (rx_frame[i][9] !== par[i]) $display("FAIL parity_bit%0d: got %b expected %b", i, rx_frame[i][9], par[i]); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            n_total++; if (rx_start[i + 1] - rx_start[i] !== P) $display("FAIL parity_spacing%0d: got %0d expected %0d", i, rx_start[i + 1] - rx_start[i], P); else n_pass++;
        end
        wait_idle(P, "parity_idle");
    endtask

    task automatic test_fifo_full;
        int k, s0;
        clear_rx();
        inhibit = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 9; i++) begin
            bif.in_data = 8'h10 + 8'(i);
            bif.in_valid = 1'b1;
            n_total++; if (bif.in_ready !== (i < DEPTH)) $display("FAIL full_ready%0d: got %b expected %b", i, bif.in_ready, (i < DEPTH)); else n_pass++;
            tick();
        end
        bif.in_valid = 1'b0;
        repeat (5) tick();
        n_total++; if (busy !== 1'b0) $display("FAIL full_inhibited_busy: got %b expected 0", busy); else n_pass++;
        s0 = n_starts;
        inhibit = 1'b0;
        k = 0;
        while (n_starts == s0 && k < 20) begin
            tick();
            k++;
        end
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b expected 1", bif.in_ready); else n_pass++;
        wait_frames(8, 8 * P + 50, "full_frames");
        for (int i = 0; i < 8; i++) begin
            n_total++; if (rx_frame[i] !== model_frame(8'h10 + 8'(i))) $display("FAIL full_order%0d: got %b expected %b", i, rx_frame[i], model_frame(8'h10 + 8'(i))); else n_pass++;
        end
        for (int i = 0; i < 7; i++) begin
            n_total++; if (rx_start[i + 1] - rx_start[i] !== P) $display("FAIL full_spacing%0d: got %0d expected %0d", i, rx_start[i + 1] - rx_start[i], P); else n_pass++;
        end
        wait_idle(2 * P, "full_idle");
        n_total++; if (rx_frame.size() !== 8) $display("FAIL full_count: got %0d expected 8", rx_frame.size()); else n_pass++;
    endtask

    task automatic test_inhibit_abort;
        int t, k, viol;
        clear_rx();
        push_byte(8'hA5, t);
        push_byte(8'h3C, t);
        k = 0;
        while (nbits != 6 && k < 2 * P) begin
            tick();
            k++;
        end
        inhibit = 1'b1;
        tick();
        tick();
        n_total++; if ({ps2_clk, ps2_data} !== 2'b11) $display("FAIL abort_lines: got %b expected 11", {ps2_clk, ps2_data}); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", busy); else n_pass++;
        viol = 0;
        repeat (30) begin
            tick();
            if ({ps2_clk, ps2_data, busy} !== 3'b111) viol++;
        end
        n_total++; if (viol !== 0) $display("FAIL abort_hold: got %0d bad cycles expected 0", viol); else n_pass++;
        inhibit = 1'b0;
        wait_frames(2, 3 * P, "abort_frames");
        n_total++; if (rx_frame[0] !== model_frame(8'hA5)) $display("FAIL abort_retx: got %b expected %b", rx_frame[0], model_frame(8'hA5)); else n_pass++;
        n_total++; if (rx_frame[1] !== model_frame(8'h3C)) $display("FAIL abort_next: got %b expected %b", rx_frame[1], model_frame(8'h3C)); else n_pass++;
        wait_idle(2 * P, "abort_idle");
        n_total++; if (rx_frame.size() !== 2) $display("FAIL abort_count: got %0d expected 2", rx_frame.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int t, k, s0;
        clear_rx();
        push_byte(8'h55, t);
        push_byte(8'h66, t);
        push_byte(8'h77, t);
        push_byte(8'h88, t);
        k = 0;
        while (nbits != 4 && k < 2 * P) begin
            tick();
            k++;
        end
        s0 = n_starts;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_total++; if ({ps2_clk, ps2_data} !== 2'b11) $display("FAIL rst_lines: got %b expected 11", {ps2_clk, ps2_data}); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", bif.in_ready); else n_pass++;
        repeat (3 * P) tick();
        n_total++; if (rx_frame.size() !== 0) $display("FAIL rst_no_frames: got %0d expected 0", rx_frame.size()); else n_pass++;
        n_total++; if (n_starts !== s0) $display("FAIL rst_no_starts: got %0d expected %0d", n_starts, s0); else n_pass++;
    endtask

    task automatic test_streaming;
        int ta, t, s, k;
        clear_rx();
        push_byte(8'h3A, ta);
        push_byte(8'hB7, t);
        s = ta + 2;
        k = 0;
        while (cyc < s + P - 1 && k < 2 * P) begin
            tick();
            k++;
        end
        bif.in_data = 8'hC4;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        n_total++; if (bif.in_ready !== 1'b1) $display("FAIL stream_ready: got %b expected 1", bif.in_ready); else n_pass++;
        wait_frames(3, 3 * P + 20, "stream_frames");
        n_total++; if (rx_frame[0] !== model_frame(8'h3A)) $display("FAIL stream_b0: got %b expected %b", rx_frame[0], model_frame(8'h3A)); else n_pass++;
        n_total++; if (rx_frame[1] !== model_frame(8'hB7)) $display("FAIL stream_b1: got %b expected %b", rx_frame[1], model_frame(8'hB7)); else n_pass++;
        n_total++; if (rx_frame[2] !== model_frame(8'hC4)) $display("FAIL stream_b2: got %b expected %b", rx_frame[2], model_frame(8'hC4)); else n_pass++;
        n_total++; if (rx_start[1] !== s + P) $display("FAIL stream_pop_time: got %0d expected %0d", rx_start[1], s + P); else n_pass++;
        n_total++; if (rx_start[2] !== s + 2 * P) $display("FAIL stream_third: got %0d expected %0d", rx_start[2], s + 2 * P); else n_pass++;
        wait_idle(2 * P, "stream_idle");
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        int t, k;
        localparam int N = 12;
        clear_rx();
        for (int i = 0; i < N; i++) begin
            k = 0;
            while (bif.in_ready !== 1'b1 && k < 2 * P) begin
                tick();
                k++;
            end
            b = 8'($urandom);
            push_byte(b, t);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 3)) tick();
        end
        for (int p = 0; p < 4; p++) begin
            repeat ($urandom_range(10, 120)) tick();
            inhibit = 1'b1;
            repeat ($urandom_range(1, 25)) tick();
            inhibit = 1'b0;
        end
        wait_frames(N, 2 * N * P + 1000, "rand_frames");
        for (int i = 0; i < N; i++) begin
            n_total++; if (rx_frame[i] !== model_frame(exp_q[i])) $display("FAIL rand_frame%0d: got %b expected %b", i, rx_frame[i], model_frame(exp_q[i])); else n_pass++;
        end
        wait_idle(2 * P, "rand_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.in_data = '0;
        bif.in_valid = 1'b0;
        test_reset();
        test_single();
        test_parity();
        test_fifo_full();
        test_inhibit_abort();
        test_reset_mid();
        test_streaming();
        test_random();
        n_total++; if (stab_err !== 0) $display("FAIL data_stability: got %0d changes while clock low expected 0", stab_err); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Device-side PS/2 transmitter: accepts scancode bytes over a valid/ready interface, buffers them in a small FIFO, and serialises each byte as an 11-bit PS/2 frame, generating both `ps2_clk` and `ps2_data`. It is the keyboard end of the link and drives the host-side PS/2 receiver in the same design. It is used for self-test benches and for injecting keystrokes on-chip without the board's keyboard model. Supports host inhibit, with abort and retransmit.

## Interface
- `HALF_PERIOD`, default 8: `clk` cycles per `ps2_clk` phase (high or low). Must be ≥ 2.
- `GAP_CYCLES`, default 32: idle `clk` cycles (lines high) after each frame. Must be ≥ 1.
- `FIFO_DEPTH`, default 8: byte FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: reset, synchronous, active-low.
- `in_data` in 8: byte to send.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: FIFO not full.
- `inhibit` in 1: host inhibit. While high, no frame starts and any frame in flight is aborted.
- `ps2_clk` out 1: generated PS/2 clock. Registered; idle high.
- `ps2_data` out 1: PS/2 data. Registered; idle high.
- `busy` out 1: a frame, gap, or pending retransmit is in progress.

## Operation
- **Push.** A byte is accepted on any `clk` edge where `in_valid && in_ready`. `in_ready = (fifo_count != FIFO_DEPTH)`.
- **Simultaneous push and pop.** Both are allowed in the same cycle when the FIFO is non-empty and not full; the count is unchanged. Pushes while full are impossible, because `in_ready` is 0.
- **Frame format.** Start bit 0, then d0..d7 LSB first, then odd parity (`~^data`), then stop bit 1. This gives 11 bits and 11 `ps2_clk` falling edges.
- **State machine.** States are IDLE, HIGH, LOW, GAP.
  - **IDLE.** If `!inhibit && (pending || fifo non-empty)`:
    - If `!pending`, pop the FIFO head into the shift register.
    - Set `bit_idx = 0` and drive `ps2_data` to the start bit.
    - Go to HIGH.
  - **HIGH.** `ps2_clk = 1` for HALF_PERIOD cycles, then go to LOW.
  - **LOW.** `ps2_clk = 0` for HALF_PERIOD cycles. Then:
    - If `bit_idx == 10`, go to GAP.
    - Otherwise increment `bit_idx`, drive `ps2_data` to the next bit, and go to HIGH.
  - **GAP.** `ps2_clk = 1` and `ps2_data = 1` for GAP_CYCLES cycles, then go to IDLE.
- **Data stability.** `ps2_data` changes only on the cycle that enters HIGH. It is stable across every falling edge and the following low phase.
- **Inhibit in HIGH or LOW.** Abort the frame on the next edge:
  - `ps2_clk = 1`, `ps2_data = 1`.
  - `pending = 1`; the shift register keeps the byte.
  - Go to IDLE.
  - After `inhibit` falls, the whole frame restarts from the start bit. No pop occurs.
- **Inhibit in GAP.** The gap completes, then the block waits in IDLE.
- **Pending.** `pending` clears when a frame reaches GAP.
- **`busy`.** `busy = (state != IDLE) || pending`.
- **Reset.** Reset mid-frame discards the frame, the FIFO contents and `pending`. Lines are high the cycle after reset.
- **Reset values.** `ps2_clk = 1`, `ps2_data = 1`, `busy = 0`, FIFO empty (`in_ready = 1`), state IDLE, `pending = 0`.

## Timing
- **Start latency.** Byte accepted at edge t with the FIFO empty and idle: the FIFO shows non-empty after t+1, and `ps2_data = 0` is first visible after edge t+2.
- **Edge placement.** The first falling edge of `ps2_clk` occurs HALF_PERIOD cycles after the start bit appears. Falling edge k (k = 0..10) presents bit k.
- **Frame length.** A frame occupies 22·HALF_PERIOD cycles plus GAP_CYCLES. Back-to-back bytes start every 22·HALF_PERIOD + GAP_CYCLES + 1 cycles.
- **Abort latency.** `inhibit` sampled high at edge t forces both lines high after edge t+1.

## Test plan
- **Single byte.** Push 0x1C while idle → 11 falling edges; data at the edges is 0,0,0,1,1,1,0,0,0,0(parity),1. Start bit appears 2 cycles after the push. A host-side receiver reports 0x1C.
- **Parity corners.** Push 0x00 → parity 1. Push 0xFF → parity 1. Push 0x01 → parity 0. In each case the stop bit is 1 and the lines are high for GAP_CYCLES afterwards.
- **FIFO full.** With `inhibit = 1`, push 9 bytes 0x10..0x18 back-to-back → 8 are accepted and `in_ready = 0` on the 9th. Release inhibit → frames 0x10..0x17 are sent in order with exact gap spacing, and `in_ready` returns to 1 after the first pop.
- **Inhibit abort.** Assert `inhibit` during bit 5 of 0xA5 → lines are high 2 edges later and `busy` stays 1. Release it → 0xA5 is retransmitted in full, and the next FIFO byte follows afterwards.
- **Reset mid-frame.** Drop `resetn` for 1 cycle during bit 3 with 3 bytes queued → lines high, `busy = 0`, `in_ready = 1`, and no further frames.
- **Streaming push and pop.** Push a new byte on the same cycle as a pop with the FIFO at count 1 → the count stays 1 and the byte order is preserved.
